// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display scanner: segment codes, update FSM states
// and per-slot anode patterns.
package bcd_disp_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } upd_state_t;

    localparam logic [3:0] AN_IDX0 = 4'b1110;
    localparam logic [3:0] AN_IDX1 = 4'b1101;
    localparam logic [3:0] AN_IDX2 = 4'b1011;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        case (idx)
            2'd0:    return AN_IDX0;
            2'd1:    return AN_IDX1;
            2'd2:    return AN_IDX2;
            default: return AN_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module seg7_bcd_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Requests periodic BCD conversions, buffers the result and scans it onto a
// 3-digit common-anode display. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int UPD_DIV     = 5000000,
    parameter int TMO         = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       listo,
    input  logic       fin,
    input  logic [3:0] Rcentenas,
    input  logic [3:0] Rdecenas,
    input  logic [3:0] Runidades,
    output logic       convierte,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       stale
);

    localparam int REF_W = $clog2(REFRESH_DIV + 1);
    localparam int UPD_W = $clog2(UPD_DIV + 1);
    localparam int TMO_W = $clog2(TMO + 1);

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPD_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    upd_state_t       r_state;
    logic [UPD_W-1:0] r_upd;
    logic [TMO_W-1:0] r_tmo;
    logic [3:0]       r_d2, r_d1, r_d0;
    logic [REF_W-1:0] r_refresh;
    logic [1:0]       r_idx;

    logic [3:0]       w_digit;
    logic [6:0]       w_seg;
    logic             w_blank;

    // Update FSM: convierte is registered so it is high exactly while in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_upd     <= '0;
            r_tmo     <= '0;
            convierte <= 1'b0;
            stale     <= 1'b0;
            r_d2      <= 4'd0;
            r_d1      <= 4'd0;
            r_d0      <= 4'd0;
        end else begin
            convierte <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_upd == UPD_LAST) begin
                        if (listo) begin
                            r_upd     <= '0;
                            r_state   <= REQ;
                            convierte <= 1'b1;
                        end
                    end else begin
                        r_upd <= r_upd + 1'b1;
                    end
                end
                REQ: begin
                    r_tmo   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // fin takes priority over a timeout on the same edge
                    if (fin) begin
                        r_d2    <= Rcentenas;
                        r_d1    <= Rdecenas;
                        r_d0    <= Runidades;
                        stale   <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_tmo == TMO_LAST) begin
                        stale   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_digit = r_d0;
        case (r_idx)
            2'd1:    w_digit = r_d1;
            2'd2:    w_digit = r_d2;
            default: w_digit = r_d0;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd2:    w_blank = (r_d2 == 4'd0);
            2'd1:    w_blank = (r_d2 == 4'd0) && (r_d1 == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    seg7_bcd_decode u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Scan: index walks 0..2 only; outputs lag index/buffer by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
        end else begin
            if (r_refresh == REF_LAST) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            an  <= anode_for(r_idx);
            seg <= w_blank ? SEG_OFF : w_seg;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a procedural converter model.
// Expected segment values follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       listo = 1'b1;
    logic       fin = 1'b0;
    logic [3:0] Rcentenas = 4'd0;
    logic [3:0] Rdecenas  = 4'd0;
    logic [3:0] Runidades = 4'd0;
    logic       convierte;
    logic [6:0] seg;
    logic [3:0] an;
    logic       stale;

    int n_chk = 0;
    int n_err = 0;
    logic [3:0] e2 = 4'd0, e1 = 4'd0, e0 = 4'd0;

    bcd_display_scan #(
        .REFRESH_DIV (4),
        .UPD_DIV     (16),
        .TMO         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .listo     (listo),
        .fin       (fin),
        .Rcentenas (Rcentenas),
        .Rdecenas  (Rdecenas),
        .Runidades (Runidades),
        .convierte (convierte),
        .seg       (seg),
        .an        (an),
        .stale     (stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int slot);
        logic [3:0] v;
        v = (slot == 0) ? e0 : (slot == 1) ? e1 : e2;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 2 && e2 == 4'd0) return 7'b1111111;
        if (slot == 1 && e2 == 4'd0 && e1 == 4'd0) return 7'b1111111;
`endif
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        do begin
            cycle();
            cyc++;
        end while (!convierte && cyc < 100);
        check("req_seen", convierte, 1'b1);
    endtask

    // Called at the negedge where convierte was first seen.
    task automatic answer(input int dly, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        repeat (dly) @(posedge clk);
        @(negedge clk);
        fin = 1'b1;
        Rcentenas = h;
        Rdecenas  = t;
        Runidades = u;
        cycle();
        fin = 1'b0;
        Rcentenas = 4'd9;
        Rdecenas  = 4'd9;
        Runidades = 4'd9;
        e2 = h;
        e1 = t;
        e0 = u;
    endtask

    task automatic scan_check(input string tag);
        logic [2:0] seen;
        seen = 3'b000;
        for (int i = 0; i < 12; i++) begin
            cycle();
            case (an)
                4'b1110: begin seen[0] = 1'b1; check({tag, "_s0"}, seg, exp_seg(0)); end
                4'b1101: begin seen[1] = 1'b1; check({tag, "_s1"}, seg, exp_seg(1)); end
                4'b1011: begin seen[2] = 1'b1; check({tag, "_s2"}, seg, exp_seg(2)); end
                default: check({tag, "_an"}, an, 4'b1110);
            endcase
        end
        check({tag, "_seen"}, seen, 3'b111);
    endtask

    initial begin
        int cyc;
        int pulses;

        #1 rst = 1'b1;
        #2;
        check("rst_conv", convierte, 1'b0);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_stale", stale, 1'b0);
        repeat (2) cycle();
        check("rst_hold_an", an, 4'b1111);
        rst = 1'b0;

        cycle();
        check("frame1_an", an, 4'b1110);
        check("frame1_seg", seg, 7'b1000000);

        // one edge already spent on the first-frame check, so 15 more to the pulse
        wait_req(cyc);
        check("req_latency", cyc, 15);
        fork
            begin
                cycle();
                check("req_width", convierte, 1'b0);
            end
        join_none
        // fin lands on the same edge as the timeout: capture must win
        answer(8, 4'd2, 4'd5, 4'd5);
        check("fin_wins_stale", stale, 1'b0);
        scan_check("scan255");

        wait_req(cyc);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("tmo_pre_stale", stale, 1'b0);
        cycle();
        check("tmo_stale", stale, 1'b1);
        scan_check("keep255");

        wait_req(cyc);
        answer(2, 4'd0, 4'd0, 4'd7);
        check("ok_stale", stale, 1'b0);
        scan_check("scan007");

        listo = 1'b0;
        pulses = 0;
        repeat (26) begin
            cycle();
            if (convierte) pulses++;
        end
        check("listo_low_pulses", pulses, 0);
        listo = 1'b1;
        cycle();
        check("listo_rise_req", convierte, 1'b1);
        answer(1, 4'd0, 4'd4, 4'd0);
        scan_check("scan040");

        wait_req(cyc);
        answer(1, 4'd0, 4'd0, 4'hC);
        scan_check("dash");

        wait_req(cyc);
        #2 rst = 1'b1;
        #1;
        check("arst_conv", convierte, 1'b0);
        check("arst_an", an, 4'b1111);
        check("arst_seg", seg, 7'b1111111);
        check("arst_stale", stale, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        e2 = 4'd0;
        e1 = 4'd0;
        e0 = 4'd0;
        cycle();
        check("post_rst_an", an, 4'b1110);
        check("post_rst_seg", seg, 7'b1000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
